// File: rtl/barrier_release_ctrl_if.sv
// barrier_release_ctrl_if: barrier arrival/release handshake bundle between the core array and the controller
interface barrier_release_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int GEN_W     = 4
);
  logic [NUM_CORES-1:0] core_en;
  logic [NUM_CORES-1:0] arrive;
  logic [NUM_CORES-1:0] release_ack;
  logic                 clear_err;
  logic [NUM_CORES-1:0] release_req;
  logic                 barrier_done;
  logic [GEN_W-1:0]     generation;
  logic [NUM_CORES-1:0] arrived;
  logic                 timeout_err;
  logic [NUM_CORES-1:0] missing;
  modport master (
    output core_en, arrive, release_ack, clear_err,
    input  release_req, barrier_done, generation, arrived, timeout_err, missing
  );
  modport slave (
    input  core_en, arrive, release_ack, clear_err,
    output release_req, barrier_done, generation, arrived, timeout_err, missing
  );
endinterface

// File: rtl/barrier_release_ctrl.sv
// barrier_release_ctrl: gathers per-core arrivals, releases all cores on completion, counts generations, flags timeouts
module barrier_release_ctrl #(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GEN_W          = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  barrier_release_ctrl_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GATHER  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] ERROR   = 2'd3;
  logic [1:0]           state_q, state_d;
  logic [NUM_CORES-1:0] arrived_q, arrived_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [NUM_CORES-1:0] release_q, release_d;
  logic [NUM_CORES-1:0] missing_q, missing_d;
  logic [GEN_W-1:0]     gen_q, gen_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 done_q, done_d;
  logic [NUM_CORES-1:0] effective, enabled_arrive, rel_left, pend_nxt;
  logic                 complete;
  // Disabled cores count as arrived; an all-disabled barrier can never complete.
  assign effective      = arrived_q | bus.arrive | ~bus.core_en;
  assign complete       = (&effective) && (|bus.core_en);
  assign enabled_arrive = bus.arrive & bus.core_en;
  // Release bits drop once acked; arrivals from already-released cores belong to the next generation.
  assign rel_left       = release_q & ~bus.release_ack;
  assign pend_nxt       = pending_q | (bus.arrive & ~release_q);
  // Next-state and datapath update for the barrier FSM.
  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    pending_d = pending_q;
    release_d = release_q;
    missing_d = missing_q;
    gen_d     = gen_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (|enabled_arrive) begin
        arrived_d = enabled_arrive;
        timer_d   = '0;
        state_d   = complete ? RELEASE : GATHER;
        release_d = complete ? bus.core_en : '0;
      end
      GATHER: begin
        arrived_d = arrived_q | enabled_arrive;
        timer_d   = timer_q + 1'b1;
        if (complete) begin
          state_d   = RELEASE;
          release_d = bus.core_en;
          timer_d   = '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ERROR;
          missing_d = bus.core_en & ~effective;
        end
      end
      RELEASE: begin
        release_d = rel_left;
        pending_d = pend_nxt;
        if (rel_left == '0) begin
          done_d    = 1'b1;
          gen_d     = gen_q + 1'b1;
          arrived_d = pend_nxt;
          pending_d = '0;
          timer_d   = '0;
          state_d   = (|pend_nxt) ? GATHER : IDLE;
        end
      end
      default: if (bus.clear_err) begin
        state_d   = IDLE;
        arrived_d = '0;
        missing_d = '0;
        timer_d   = '0;
      end
    endcase
  end
  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      arrived_q <= '0;
      pending_q <= '0;
      release_q <= '0;
      missing_q <= '0;
      gen_q     <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      pending_q <= pending_d;
      release_q <= release_d;
      missing_q <= missing_d;
      gen_q     <= gen_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
    end
  end
  assign bus.release_req  = release_q;
  assign bus.barrier_done = done_q;
  assign bus.generation   = gen_q;
  assign bus.arrived      = arrived_q;
  assign bus.timeout_err  = (state_q == ERROR);
  assign bus.missing      = missing_q;
endmodule

// File: tb/tb_barrier_release_ctrl.sv
// tb_barrier_release_ctrl: table vectors, corner sequences and randomized checks against a behavioural barrier model
module tb_barrier_release_ctrl;
  localparam int N = 4;
  localparam int T = 16;
  localparam int G = 4;
  localparam int P_IDLE = 0, P_GAT = 1, P_REL = 2, P_ERR = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  barrier_release_ctrl_if #(.NUM_CORES(N), .GEN_W(G)) bi();
  barrier_release_ctrl #(.NUM_CORES(N), .TIMEOUT_CYCLES(T), .GEN_W(G)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bi.slave)
  );
  int n_cmp = 0;
  int n_bad = 0;
  int m_phase, m_gen, m_timer;
  logic [N-1:0] m_arr, m_pend, m_rel, m_miss;
  logic m_done;
  typedef struct {
    logic [N-1:0] en, arr, ack;
    logic         clr;
    logic [N-1:0] rel, arrd;
    logic         done;
    logic [G-1:0] gen;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_phase = P_IDLE; m_gen = 0; m_timer = 0; m_done = 1'b0;
    m_arr = '0; m_pend = '0; m_rel = '0; m_miss = '0;
  endtask
  task automatic model_step(input logic [N-1:0] en, arr, ack, input logic clr);
    logic [N-1:0] eff, old_rel;
    bit comp;
    eff = m_arr | arr | ~en;
    comp = (eff == {N{1'b1}}) && (en != 0);
    old_rel = m_rel;
    m_done = 1'b0;
    case (m_phase)
      P_IDLE: if ((arr & en) != 0) begin
        m_arr = arr & en;
        m_timer = 0;
        if (comp) begin m_rel = en; m_phase = P_REL; end
        else m_phase = P_GAT;
      end
      P_GAT: begin
        m_arr = m_arr | (arr & en);
        if (comp) begin m_rel = en; m_phase = P_REL; end
        else if (m_timer == T - 1) begin m_miss = en & ~eff; m_phase = P_ERR; end
        else m_timer++;
      end
      P_REL: begin
        for (int i = 0; i < N; i++) begin
          if (old_rel[i] && ack[i]) m_rel[i] = 1'b0;
          if (!old_rel[i] && arr[i]) m_pend[i] = 1'b1;
        end
        if (m_rel == 0) begin
          m_done = 1'b1;
          m_gen = (m_gen + 1) % (1 << G);
          m_arr = m_pend;
          m_pend = '0;
          m_timer = 0;
          m_phase = (m_arr != 0) ? P_GAT : P_IDLE;
        end
      end
      default: if (clr) begin
        m_phase = P_IDLE; m_arr = '0; m_miss = '0; m_timer = 0;
      end
    endcase
  endtask
  task automatic cyc(input logic [N-1:0] en, arr, ack, input logic clr);
    bi.core_en = en; bi.arrive = arr; bi.release_ack = ack; bi.clear_err = clr;
    @(posedge clk);
    model_step(en, arr, ack, clr);
    #1;
    bi.arrive = '0; bi.release_ack = '0; bi.clear_err = 1'b0;
  endtask
  task automatic chk_model();
    chk("m_release", bi.release_req, m_rel);
    chk("m_arrived", bi.arrived, m_arr);
    chk("m_missing", bi.missing, m_miss);
    chk("m_generation", bi.generation, m_gen);
    chk("m_done", bi.barrier_done, m_done);
    chk("m_timeout", bi.timeout_err, m_phase == P_ERR);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int gstart;
    logic [N-1:0] en, arr, ack, slow;
    bi.core_en = '1; bi.arrive = '0; bi.release_ack = '0; bi.clear_err = 1'b0;
    model_reset();
    #12;
    chk("rst_release", bi.release_req, 0);
    chk("rst_arrived", bi.arrived, 0);
    chk("rst_missing", bi.missing, 0);
    chk("rst_gen", bi.generation, 0);
    chk("rst_done", bi.barrier_done, 0);
    chk("rst_timeout", bi.timeout_err, 0);
    @(negedge clk) rst_n = 1'b1;
    tbl.push_back('{4'hF, 4'h1, 4'h0, 1'b0, 4'h0, 4'h1, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'h2, 4'h0, 1'b0, 4'h0, 4'h3, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'h4, 4'h0, 1'b0, 4'h0, 4'h7, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'h8, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 4'd1});
    tbl.push_back('{4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'd1});
    tbl.push_back('{4'hB, 4'h1, 4'h0, 1'b0, 4'h0, 4'h1, 1'b0, 4'd1});
    tbl.push_back('{4'hB, 4'h2, 4'h0, 1'b0, 4'h0, 4'h3, 1'b0, 4'd1});
    tbl.push_back('{4'hB, 4'h8, 4'h0, 1'b0, 4'hB, 4'hB, 1'b0, 4'd1});
    tbl.push_back('{4'hB, 4'h0, 4'hB, 1'b0, 4'h0, 4'h0, 1'b1, 4'd2});
    tbl.push_back('{4'hB, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'd2});
    tbl.push_back('{4'hF, 4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 4'd2});
    tbl.push_back('{4'hF, 4'h0, 4'h1, 1'b0, 4'hE, 4'hF, 1'b0, 4'd2});
    tbl.push_back('{4'hF, 4'h1, 4'h0, 1'b0, 4'hE, 4'hF, 1'b0, 4'd2});
    tbl.push_back('{4'hF, 4'h0, 4'hE, 1'b0, 4'h0, 4'h1, 1'b1, 4'd3});
    tbl.push_back('{4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 4'h1, 1'b0, 4'd3});
    tbl.push_back('{4'hF, 4'hE, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 4'd3});
    tbl.push_back('{4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 4'd4});
    tbl.push_back('{4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'd4});
    tbl.push_back('{4'hF, 4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 4'd4});
    tbl.push_back('{4'hF, 4'h0, 4'h3, 1'b0, 4'hC, 4'hF, 1'b0, 4'd4});
    tbl.push_back('{4'hF, 4'h0, 4'h3, 1'b0, 4'hC, 4'hF, 1'b0, 4'd4});
    tbl.push_back('{4'hF, 4'h0, 4'hC, 1'b0, 4'h0, 4'h0, 1'b1, 4'd5});
    tbl.push_back('{4'hF, 4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 4'd5});
    tbl.push_back('{4'hF, 4'h3, 4'h3, 1'b0, 4'hC, 4'hF, 1'b0, 4'd5});
    tbl.push_back('{4'hF, 4'h0, 4'hC, 1'b0, 4'h0, 4'h0, 1'b1, 4'd6});
    tbl.push_back('{4'hF, 4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 4'd6});
    tbl.push_back('{4'h1, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 4'd6});
    tbl.push_back('{4'h1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 4'd7});
    foreach (tbl[k]) begin
      cyc(tbl[k].en, tbl[k].arr, tbl[k].ack, tbl[k].clr);
      chk($sformatf("tbl%0d_release", k), bi.release_req, tbl[k].rel);
      chk($sformatf("tbl%0d_arrived", k), bi.arrived, tbl[k].arrd);
      chk($sformatf("tbl%0d_done", k), bi.barrier_done, tbl[k].done);
      chk($sformatf("tbl%0d_gen", k), bi.generation, tbl[k].gen);
      chk_model();
    end
    cyc(4'hF, 4'h3, 4'h0, 1'b0);
    repeat (T - 1) cyc(4'hF, 4'h0, 4'h0, 1'b0);
    chk("to_not_yet", bi.timeout_err, 0);
    cyc(4'hF, 4'h0, 4'h0, 1'b0);
    chk("to_err", bi.timeout_err, 1);
    chk("to_missing", bi.missing, 4'hC);
    chk("to_release", bi.release_req, 0);
    chk("to_arrived", bi.arrived, 4'h3);
    cyc(4'hF, 4'hF, 4'hF, 1'b0);
    chk("err_hold_arrived", bi.arrived, 4'h3);
    chk("err_hold_missing", bi.missing, 4'hC);
    chk("err_hold_timeout", bi.timeout_err, 1);
    cyc(4'hF, 4'h0, 4'h0, 1'b1);
    chk("clr_timeout", bi.timeout_err, 0);
    chk("clr_arrived", bi.arrived, 0);
    chk("clr_missing", bi.missing, 0);
    chk("clr_gen", bi.generation, 7);
    chk_model();
    cyc(4'hF, 4'h1, 4'h0, 1'b0);
    repeat (T - 1) cyc(4'hF, 4'h0, 4'h0, 1'b0);
    cyc(4'hF, 4'hE, 4'h0, 1'b0);
    chk("race_release", bi.release_req, 4'hF);
    chk("race_timeout", bi.timeout_err, 0);
    cyc(4'hF, 4'h0, 4'hF, 1'b0);
    chk("race_gen", bi.generation, 8);
    gstart = 8;
    for (int k = 0; k < 16; k++) begin
      cyc(4'hF, 4'hF, 4'h0, 1'b0);
      chk("wrap_release", bi.release_req, 4'hF);
      cyc(4'hF, 4'h0, 4'hF, 1'b0);
      chk("wrap_done", bi.barrier_done, 1);
      chk("wrap_gen", bi.generation, (gstart + k + 1) % 16);
    end
    chk_model();
    cyc(4'hF, 4'hF, 4'h0, 1'b0);
    cyc(4'hF, 4'h0, 4'h9, 1'b0);
    chk("pre_rst_release", bi.release_req, 4'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_release", bi.release_req, 0);
    chk("arst_gen", bi.generation, 0);
    chk("arst_timeout", bi.timeout_err, 0);
    chk("arst_arrived", bi.arrived, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    en = 4'hF;
    slow = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 3))
          0: en = '0;
          1: en = 4'($urandom_range(1, 15));
          default: en = 4'hF;
        endcase
      end
      if ($urandom_range(0, 99) == 0) slow = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        arr[i] = ($urandom_range(0, slow[i] ? 39 : 5) == 0);
        ack[i] = ($urandom_range(0, 1) == 1);
      end
      cyc(en, arr, ack, $urandom_range(0, 7) == 0);
      chk_model();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
